// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, data first
// Optional feature macro: ARB_PERF_EN adds per-port stall cycle counters.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_be,
  input  logic [DW-1:0] m_rdata,
  output logic          stall_if,
  output logic          stall_mem
`ifdef ARB_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   perf_istall,
  output logic [31:0]   perf_dstall
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t        state_q;
  logic          grant_d_q;   // 1 = data port owns the current access
  logic [3:0]    cnt_q;
  logic          m_en_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [3:0]    m_be_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // Access sequencer: grant in IDLE, strobe in ISSUE, count latency in WAIT, ack in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_d_q <= 1'b0;
      cnt_q     <= 4'd0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= 4'd0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_req || i_req) begin
            grant_d_q <= d_req;
            m_en_q    <= 1'b1;
            state_q   <= ISSUE;
            if (d_req) begin
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              m_be_q    <= d_be;
            end else begin
              m_we_q   <= 1'b0;
              m_addr_q <= i_addr;
              m_be_q   <= 4'b1111;
            end
          end
        end
        ISSUE: begin
          m_en_q  <= 1'b0;
          cnt_q   <= LAT;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            // Stores complete with an ack but never disturb the load data register
            if (grant_d_q) begin
              if (!m_we_q) d_rdata_q <= m_rdata;
              d_ack_q <= 1'b1;
            end else begin
              i_rdata_q <= m_rdata;
              i_ack_q   <= 1'b1;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE first keeps the acked requester's held req from re-granting
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = i_req & ~i_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

`ifdef ARB_PERF_EN
  logic [31:0] perf_istall_q;
  logic [31:0] perf_dstall_q;

  // Saturating stall-cycle counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      perf_istall_q <= 32'd0;
      perf_dstall_q <= 32'd0;
    end else begin
      if (stall_if && perf_istall_q != 32'hFFFF_FFFF) perf_istall_q <= perf_istall_q + 32'd1;
      if (stall_mem && perf_dstall_q != 32'hFFFF_FFFF) perf_dstall_q <= perf_dstall_q + 32'd1;
    end
  end

  assign perf_istall = perf_istall_q;
  assign perf_dstall = perf_dstall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with MEM_LAT=2
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] JUNK = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;
`ifdef ARB_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_istall;
  logic [31:0] perf_dstall;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_istall(perf_istall), .perf_dstall(perf_dstall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          chk_wd;
  } m_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } r_exp_t;

  m_exp_t m_q[$];
  r_exp_t i_q[$];
  r_exp_t d_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_issue = -100;
  logic [31:0] rd_val = 32'h0;
  int t0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid only in the cycle MEM_LAT after the strobe
  assign m_rdata = (cyc == last_issue + LAT) ? rd_val : JUNK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: pulse with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or ack
  always @(posedge clk) begin
    #1;
    chk("stall_if", stall_if, i_req & ~i_ack);
    chk("stall_mem", stall_mem, d_req & ~d_ack);
    if (m_en) begin
      last_issue = cyc;
      if (m_q.size() == 0) unexpected("m_en");
      else begin
        m_exp_t e;
        e = m_q.pop_front();
        chk("m_en cycle", cyc, e.cyc);
        chk("m_we", m_we, e.we);
        chk("m_addr", m_addr, e.addr);
        chk("m_be", m_be, e.be);
        if (e.chk_wd) chk("m_wdata", m_wdata, e.wdata);
      end
    end
    if (i_ack) begin
      if (i_q.size() == 0) unexpected("i_ack");
      else begin
        r_exp_t e;
        e = i_q.pop_front();
        chk("i_ack cycle", cyc, e.cyc);
        chk("i_rdata", i_rdata, e.rdata);
      end
    end
    if (d_ack) begin
      if (d_q.size() == 0) unexpected("d_ack");
      else begin
        r_exp_t e;
        e = d_q.pop_front();
        chk("d_ack cycle", cyc, e.cyc);
        chk("d_rdata", d_rdata, e.rdata);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " m_en"}, m_en, 0);
    chk({tag, " m_we"}, m_we, 0);
    chk({tag, " m_addr"}, m_addr, 0);
    chk({tag, " m_wdata"}, m_wdata, 0);
    chk({tag, " m_be"}, m_be, 0);
    chk({tag, " i_ack"}, i_ack, 0);
    chk({tag, " d_ack"}, d_ack, 0);
    chk({tag, " i_rdata"}, i_rdata, 0);
    chk({tag, " d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_be = 0;
`ifdef ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    @(posedge clk);

    // Reset held two cycles with random inputs
    repeat (2) begin
      @(negedge clk);
      i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      #1;
      check_all_zero("reset");
      chk("reset stall_if", stall_if, i_req);
      chk("reset stall_mem", stall_mem, d_req);
`ifdef ARB_PERF_EN
      chk("reset perf_istall", perf_istall, 0);
      chk("reset perf_dstall", perf_dstall, 0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1; i_req = 0; d_req = 0; d_we = 0; d_be = 0;

    // Lone fetch
    step(1);
    t0 = cyc;
    i_req = 1; i_addr = 32'h0040_0000; rd_val = 32'h8C08_0004;
    m_q.push_back('{t0 + 1, 1'b0, 32'h0040_0000, 32'h0, 4'b1111, 1'b0});
    i_q.push_back('{t0 + 4, 32'h8C08_0004});
    step(4);
    i_req = 0;
    step(2);

    // Contention: data load first, then fetch
`ifdef ARB_PERF_EN
    perf_clr = 1'b1;
`endif
    step(1);
`ifdef ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    t0 = cyc;
    i_req = 1; i_addr = 32'h0040_0004;
    d_req = 1; d_we = 0; d_addr = 32'h1001_0000; d_be = 4'b1111;
    rd_val = 32'hCAFE_0001;
    m_q.push_back('{t0 + 1, 1'b0, 32'h1001_0000, 32'h0, 4'b1111, 1'b0});
    d_q.push_back('{t0 + 4, 32'hCAFE_0001});
    m_q.push_back('{t0 + 6, 1'b0, 32'h0040_0004, 32'h0, 4'b1111, 1'b0});
    i_q.push_back('{t0 + 9, 32'h2408_0007});
    step(4);
    d_req = 0; rd_val = 32'h2408_0007;
    step(5);
    i_req = 0;
    step(1);
`ifdef ARB_PERF_EN
    chk("perf_dstall contention", perf_dstall, 4);
    chk("perf_istall contention", perf_istall, 9);
`endif
    step(1);

    // Store: d_rdata keeps the previous load value
    t0 = cyc;
    d_req = 1; d_we = 1; d_addr = 32'h1001_0004; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    rd_val = 32'h1234_5678;
`ifdef ARB_PERF_EN
    perf_clr = 1'b1;
`endif
    m_q.push_back('{t0 + 1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b0011, 1'b1});
    d_q.push_back('{t0 + 4, 32'hCAFE_0001});
    step(1);
`ifdef ARB_PERF_EN
    perf_clr = 1'b0;
    chk("perf_istall after clr", perf_istall, 0);
    chk("perf_dstall after clr", perf_dstall, 0);
`endif
    step(3);
    d_req = 0; d_we = 0;
    step(2);

    // Reset in the middle of a fetch's WAIT phase
    t0 = cyc;
    i_req = 1; i_addr = 32'h0040_0100; rd_val = 32'h5555_AAAA;
    m_q.push_back('{t0 + 1, 1'b0, 32'h0040_0100, 32'h0, 4'b1111, 1'b0});
    step(2);
    rst_n = 1'b0;
    step(1);
    check_all_zero("mid-reset");
    rst_n = 1'b1; i_req = 0;
    step(3);

    // Fresh fetch after reset release
    t0 = cyc;
    i_req = 1; i_addr = 32'h0040_0200; rd_val = 32'h0000_0013;
    m_q.push_back('{t0 + 1, 1'b0, 32'h0040_0200, 32'h0, 4'b1111, 1'b0});
    i_q.push_back('{t0 + 4, 32'h0000_0013});
    step(4);
    i_req = 0;
    step(4);

    chk("pending m_en expectations", m_q.size(), 0);
    chk("pending i_ack expectations", i_q.size(), 0);
    chk("pending d_ack expectations", d_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
